seg_disp_arbiter: RTL and testbench

Time-shares the six-digit 74HC595 seven-segment display between up to `N_REQ` independent data sources. Each source (IIC readout, counters, status) raises a request with its own value, decimal-point mask and sign. The arbiter grants the display round-robin, with a guaranteed minimum on-screen time and an optional blanking gap between owners. Its registered `data/point/seg_en/sign` outputs drive `seg_595_dynamic` directly, replacing a single fixed `data_gen` source.

---
 rtl/seg_disp_pkg.sv | 14 +
 rtl/seg_disp_arbiter_rr_pick.sv | 29 ++
 rtl/seg_disp_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared widths and state encoding for the seven-segment display arbiter.
package seg_disp_pkg;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned POINT_W = 6;
    localparam int unsigned GID_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_e;

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// Round-robin picker: first valid source after i_ptr, wrapping, the pointer itself last.
module rr_pick
    import seg_disp_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [GID_W-1:0] i_ptr,
    output logic             o_any,
    output logic [GID_W-1:0] o_win
);

    int unsigned w_idx;

    // Scan from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        w_idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + 1 + k) % N_REQ;
            if (|(i_req_valid & (N_REQ'(1) << w_idx))) begin
                o_any = 1'b1;
                o_win = GID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Time-shares the six-digit display between N_REQ sources with a minimum hold and a blank gap.
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned HOLD_CYC  = 50_000_000,
    parameter int unsigned BLANK_CYC = 2_500_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [DATA_W*N_REQ-1:0]  req_data,
    input  logic [POINT_W*N_REQ-1:0] req_point,
    input  logic [N_REQ-1:0]         req_sign,
    output logic [N_REQ-1:0]         req_ack,
    output logic [GID_W-1:0]         grant_id,
    output logic [DATA_W-1:0]        data,
    output logic [POINT_W-1:0]       point,
    output logic                     seg_en,
    output logic                     sign
);

    localparam int unsigned HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_e               r_state, w_state_d;
    logic [HOLD_W-1:0]    r_hold, w_hold_d;
    logic [BLANK_W-1:0]   r_blank, w_blank_d;
    logic [GID_W-1:0]     r_ptr;
    logic [GID_W-1:0]     r_grant_id;
    logic [N_REQ-1:0]     r_ack;
    logic [DATA_W-1:0]    r_data;
    logic [POINT_W-1:0]   r_point;
    logic                 r_sign;
    logic                 r_seg_en;

    logic                 w_any;
    logic [GID_W-1:0]     w_win;
    logic                 w_grant;
    logic                 w_expired;
    logic [N_REQ-1:0]     w_own_mask;
    logic                 w_owner_valid;
    logic                 w_other_valid;
    logic [DATA_W-1:0]    w_win_data, w_own_data;
    logic [POINT_W-1:0]   w_win_point, w_own_point;
    logic                 w_win_sign, w_own_sign;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .o_any       (w_any),
        .o_win       (w_win)
    );

    assign w_own_mask    = N_REQ'(1) << r_grant_id;
    assign w_owner_valid = |(req_valid & w_own_mask);
    assign w_other_valid = |(req_valid & ~w_own_mask);
    assign w_expired     = (r_hold == HOLD_LAST);

    // Select the winner's and the current owner's fields from the packed request buses.
    always_comb begin
        w_win_data  = '0;
        w_win_point = '0;
        w_win_sign  = 1'b0;
        w_own_data  = '0;
        w_own_point = '0;
        w_own_sign  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == GID_W'(i)) begin
                w_win_data  = req_data[i*DATA_W +: DATA_W];
                w_win_point = req_point[i*POINT_W +: POINT_W];
                w_win_sign  = req_sign[i];
            end
            if (r_grant_id == GID_W'(i)) begin
                w_own_data  = req_data[i*DATA_W +: DATA_W];
                w_own_point = req_point[i*POINT_W +: POINT_W];
                w_own_sign  = req_sign[i];
            end
        end
    end

    // Next-state logic: grants, hold/blank counting and owner changes.
    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold;
        w_blank_d = r_blank;
        w_grant   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant   = 1'b1;
                    w_state_d = SHOW;
                    w_hold_d  = '0;
                end
            end
            SHOW: begin
                if (!w_expired) begin
                    w_hold_d = r_hold + HOLD_W'(1);
                end else if (w_other_valid) begin
                    if (BLANK_CYC == 0) begin
                        w_grant  = 1'b1;
                        w_hold_d = '0;
                    end else begin
                        w_state_d = BLANK;
                        w_blank_d = '0;
                    end
                end else if (!w_owner_valid) begin
                    w_state_d = IDLE;
                end
            end
            BLANK: begin
                if (r_blank == BLANK_LAST) begin
                    if (w_any) begin
                        w_grant   = 1'b1;
                        w_state_d = SHOW;
                        w_hold_d  = '0;
                    end else begin
                        w_state_d = IDLE;
                    end
                end else begin
                    w_blank_d = r_blank + BLANK_W'(1);
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_blank <= '0;
        end else begin
            r_state <= w_state_d;
            r_hold  <= w_hold_d;
            r_blank <= w_blank_d;
        end
    end

    // Output registers: latch on grant, follow a valid owner while shown, otherwise hold.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ptr      <= GID_W'(N_REQ - 1);
            r_grant_id <= '0;
            r_ack      <= '0;
            r_data     <= '0;
            r_point    <= '0;
            r_sign     <= 1'b0;
            r_seg_en   <= 1'b0;
        end else begin
            r_ack    <= '0;
            r_seg_en <= (w_state_d == SHOW);
            if (w_grant) begin
                r_ptr      <= w_win;
                r_grant_id <= w_win;
                r_ack      <= N_REQ'(1) << w_win;
                r_data     <= w_win_data;
                r_point    <= w_win_point;
                r_sign     <= w_win_sign;
            end else if (r_state == SHOW && w_owner_valid) begin
                r_data  <= w_own_data;
                r_point <= w_own_point;
                r_sign  <= w_own_sign;
            end
        end
    end

    assign req_ack  = r_ack;
    assign grant_id = r_grant_id;
    assign data     = r_data;
    assign point    = r_point;
    assign sign     = r_sign;
    assign seg_en   = r_seg_en;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Scoreboard bench for seg_disp_arbiter with HOLD_CYC=8, BLANK_CYC=2, N_REQ=4.
module tb_seg_disp_arbiter;

    localparam int unsigned N = 4;

    typedef struct packed {
        logic        en;
        logic [19:0] data;
        logic [5:0]  pt;
        logic        sg;
        logic [3:0]  ack;
        logic [2:0]  gid;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [79:0]   req_data;
    logic [23:0]   req_point;
    logic [N-1:0]  req_sign;
    logic [N-1:0]  req_ack;
    logic [2:0]    grant_id;
    logic [19:0]   data;
    logic [5:0]    point;
    logic          seg_en;
    logic          sign;

    logic [19:0]   src_d [N];
    logic [5:0]    src_p [N];
    logic          src_s [N];

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data[g*20 +: 20] = src_d[g];
        assign req_point[g*6 +: 6]  = src_p[g];
        assign req_sign[g]          = src_s[g];
    end

    seg_disp_arbiter #(
        .N_REQ     (N),
        .HOLD_CYC  (8),
        .BLANK_CYC (2)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_point (req_point),
        .req_sign  (req_sign),
        .req_ack   (req_ack),
        .grant_id  (grant_id),
        .data      (data),
        .point     (point),
        .seg_en    (seg_en),
        .sign      (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic en, input logic [19:0] d, input logic [5:0] p,
                                input logic s, input logic [3:0] ack, input int gid);
        exp_t e;
        e.en   = en;
        e.data = d;
        e.pt   = p;
        e.sg   = s;
        e.ack  = ack;
        e.gid  = 3'(gid);
        return e;
    endfunction

    // Expectation built from the bench's own source tables for source i.
    function automatic exp_t mk_src(input logic en, input int i, input logic [3:0] ack);
        return mk(en, src_d[i], src_p[i], src_s[i], ack, i);
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'd1;
        return one << i;
    endfunction

    // One clock: the expectation applies to the outputs right after this edge.
    task automatic cyc(input exp_t e);
        @(posedge clk);
        sb.push_back(e);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("seg_en", 32'(seg_en), 32'(mon_e.en));
            check("data", 32'(data), 32'(mon_e.data));
            check("point", 32'(point), 32'(mon_e.pt));
            check("sign", 32'(sign), 32'(mon_e.sg));
            check("req_ack", 32'(req_ack), 32'(mon_e.ack));
            check("grant_id", 32'(grant_id), 32'(mon_e.gid));
        end
    end

    // Owner cur shows 7 more cycles, blanks 2, then nxt is granted.
    task automatic rotate(input int cur, input int nxt);
        for (int i = 0; i < 7; i++) cyc(mk_src(1'b1, cur, 4'b0));
        for (int i = 0; i < 2; i++) cyc(mk_src(1'b0, cur, 4'b0));
        cyc(mk_src(1'b1, nxt, oh(nxt)));
    endtask

    initial begin
        src_d[0] = 20'd123456; src_p[0] = 6'b000100; src_s[0] = 1'b0;
        src_d[1] = 20'd111;    src_p[1] = 6'b000000; src_s[1] = 1'b0;
        src_d[2] = 20'd42;     src_p[2] = 6'b110000; src_s[2] = 1'b0;
        src_d[3] = 20'd333;    src_p[3] = 6'b001010; src_s[3] = 1'b1;

        // Reset state, then idle with nothing requested.
        cyc(mk(1'b0, 20'd0, 6'd0, 1'b0, 4'b0, 0));
        cyc(mk(1'b0, 20'd0, 6'd0, 1'b0, 4'b0, 0));
        rst = 1'b0;
        cyc(mk(1'b0, 20'd0, 6'd0, 1'b0, 4'b0, 0));

        // First grant goes to source 0 one cycle after its request.
        req_valid = 4'b0001;
        cyc(mk_src(1'b1, 0, 4'b0001));

        // Source 2 arrives early but must wait for the full hold plus blank.
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) req_valid = 4'b0101;
            cyc(mk_src(1'b1, 0, 4'b0));
        end
        for (int i = 0; i < 2; i++) cyc(mk_src(1'b0, 0, 4'b0));
        cyc(mk_src(1'b1, 2, 4'b0100));

        // Everyone requesting: strict rotation 2 -> 3 -> 0 -> 1.
        req_valid = 4'b1111;
        rotate(2, 3);
        rotate(3, 0);
        rotate(0, 1);

        // Owner 1 drops after two cycles: frozen value, then idle.
        req_valid = 4'b0010;
        cyc(mk_src(1'b1, 1, 4'b0));
        cyc(mk_src(1'b1, 1, 4'b0));
        req_valid = 4'b0000;
        src_d[1]  = 20'd999;
        for (int i = 0; i < 5; i++) cyc(mk(1'b1, 20'd111, 6'd0, 1'b0, 4'b0, 1));
        for (int i = 0; i < 3; i++) cyc(mk(1'b0, 20'd111, 6'd0, 1'b0, 4'b0, 1));

        // Sole owner 3 with live-changing data: tracks, never re-acked or blanked.
        src_d[3]  = 20'd0;
        req_valid = 4'b1000;
        cyc(mk_src(1'b1, 3, 4'b1000));
        for (int v = 1; v <= 20; v++) begin
            src_d[3] = 20'(v);
            cyc(mk_src(1'b1, 3, 4'b0));
        end

        // Source 0 joins after expiry: blank, then reset inside blank.
        req_valid = 4'b1001;
        cyc(mk_src(1'b0, 3, 4'b0));
        rst = 1'b1;
        cyc(mk(1'b0, 20'd0, 6'd0, 1'b0, 4'b0, 0));
        rst = 1'b0;
        cyc(mk_src(1'b1, 0, 4'b0001));

        // Reset mid-show; pointer restart gives source 0 priority over 3 again.
        cyc(mk_src(1'b1, 0, 4'b0));
        cyc(mk_src(1'b1, 0, 4'b0));
        rst = 1'b1;
        cyc(mk(1'b0, 20'd0, 6'd0, 1'b0, 4'b0, 0));
        rst = 1'b0;
        cyc(mk_src(1'b1, 0, 4'b0001));
        cyc(mk_src(1'b1, 0, 4'b0));

        repeat (3) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
